// File: rtl/sd_ctrl_axil_slave.sv
// sd_ctrl_axil_slave
//   AXI4-Lite register window for the SD-card controller.
//   Map (word address = ADDR[5:2]):
//     0x00 CTRL     bit0 START (self-clearing, reads 0), bits[7:1] RW
//     0x04 STATUS   bit0 sd_busy (live), bit1 DONE (sticky, write 1 to clear)
//     0x08 SECTOR   RW, drives cmd_sector
//     0x0C SCRATCH  RW
//     0x10-0x1C     unmapped (SLVERR, reads 0)
//     0x20-0x3C     data buffer, RW
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*        write address, data and response channels
//   S_AXI_AR*/R*           read address and data channels
//   cmd_start              one-cycle pulse after a START write commits
//   cmd_sector             current SECTOR register
//   sd_busy, sd_done       SD engine busy level and completion pulse
module sd_ctrl_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int BUF_WORDS          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            cmd_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   cmd_sector,
    input  logic                            sd_busy,
    input  logic                            sd_done
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
    localparam int BI = $clog2(BUF_WORDS);

    localparam logic [WA-1:0] A_CTRL    = WA'(0);
    localparam logic [WA-1:0] A_STATUS  = WA'(1);
    localparam logic [WA-1:0] A_SECTOR  = WA'(2);
    localparam logic [WA-1:0] A_SCRATCH = WA'(3);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_held;
    logic [WA-1:0] aw_word;
    logic          w_held;
    logic [DW-1:0] w_data;
    logic [SW-1:0] w_strb;

    logic [7:1]    ctrl_q;
    logic          done_q;
    logic [DW-1:0] sector_q;
    logic [DW-1:0] scratch_q;
    logic [DW-1:0] buf_q [BUF_WORDS];

    logic          aw_fire, w_fire, ar_fire, wr_commit;
    logic [WA-1:0] wr_word, rd_word;
    logic [DW-1:0] wr_data, rd_data;
    logic [SW-1:0] wr_strb;
    logic          wr_mapped, rd_mapped, status_clr;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic is_mapped(input logic [WA-1:0] w);
        // words 0..3 are registers, the upper half is the buffer
        return (w[WA-1:2] == '0) || w[WA-1];
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] data,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < SW; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    // Ready is forced low while reset is asserted so nothing handshakes then.
    assign S_AXI_AWREADY = !ARESET && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = !ARESET && !w_held  && !S_AXI_BVALID;
    assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;

    // Commit on the edge where the later of AW and W arrives; the earlier one
    // comes from the holding register, the later one straight off the bus.
    assign wr_commit = (aw_held || aw_fire) && (w_held || w_fire);
    assign wr_word   = aw_held ? aw_word : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data   = w_held  ? w_data  : S_AXI_WDATA;
    assign wr_strb   = w_held  ? w_strb  : S_AXI_WSTRB;
    assign wr_mapped = is_mapped(wr_word);

    assign status_clr = wr_commit && (wr_word == A_STATUS) && wr_strb[0] && wr_data[1];

    assign rd_word    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_mapped  = is_mapped(rd_word);
    assign cmd_sector = sector_q;

    always_comb begin
        rd_data = '0;
        case (rd_word)
            A_CTRL:    rd_data = {{(DW-8){1'b0}}, ctrl_q, 1'b0};
            A_STATUS:  rd_data = {{(DW-2){1'b0}}, done_q, sd_busy};
            A_SECTOR:  rd_data = sector_q;
            A_SCRATCH: rd_data = scratch_q;
            default:   if (rd_word[WA-1]) rd_data = buf_q[rd_word[BI-1:0]];
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held      <= 1'b0;
            aw_word      <= '0;
            w_held       <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
            cmd_start    <= 1'b0;
            ctrl_q       <= '0;
            done_q       <= 1'b0;
            sector_q     <= '0;
            scratch_q    <= '0;
            for (int i = 0; i < BUF_WORDS; i++) buf_q[i] <= '0;
        end else begin
            cmd_start <= 1'b0;

            if (aw_fire && !wr_commit) begin
                aw_held <= 1'b1;
                aw_word <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_fire && !wr_commit) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end

            if (wr_commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                case (wr_word)
                    A_CTRL: if (wr_strb[0]) begin
                        ctrl_q    <= wr_data[7:1];
                        cmd_start <= wr_data[0];
                    end
                    A_STATUS:  ;
                    A_SECTOR:  sector_q  <= merge(sector_q, wr_data, wr_strb);
                    A_SCRATCH: scratch_q <= merge(scratch_q, wr_data, wr_strb);
                    default: if (wr_word[WA-1])
                        buf_q[wr_word[BI-1:0]] <= merge(buf_q[wr_word[BI-1:0]], wr_data, wr_strb);
                endcase
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            // a completion arriving with the clear keeps DONE set
            done_q <= sd_done | (done_q & ~status_clr);

            if (ar_fire) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data;
                S_AXI_RRESP  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule
